// File: rtl/sad_result_scheduler_if.sv
// Result handshake bundle between the motion-estimation cores
// and the SAD scheduler: per-core valid/data in, one-hot ready out.
interface sad_result_scheduler_if #(
  parameter int NUM_CORES = 8,
  parameter int SAD_W     = 32,
  parameter int IDX_W     = 8
);
  logic [NUM_CORES-1:0]       ReqValid;
  logic [NUM_CORES*SAD_W-1:0] ReqSAD;
  logic [NUM_CORES*IDX_W-1:0] ReqRow;
  logic [NUM_CORES*IDX_W-1:0] ReqCol;
  logic [NUM_CORES-1:0]       ReqReady;

  modport master (
    output ReqValid,
    output ReqSAD,
    output ReqRow,
    output ReqCol,
    input  ReqReady
  );

  modport slave (
    input  ReqValid,
    input  ReqSAD,
    input  ReqRow,
    input  ReqCol,
    output ReqReady
  );
endinterface

// File: rtl/sad_result_scheduler.sv
// Round-robin collector feeding a running-minimum SAD tracker;
// pulses Done once the programmed number of results is accepted.
module sad_result_scheduler #(
  parameter int NUM_CORES = 8,
  parameter int SAD_W     = 32,
  parameter int IDX_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic [CNT_W-1:0]             ExpectedCount,
  sad_result_scheduler_if.slave        req,
  output logic [SAD_W-1:0]             MinSAD,
  output logic [IDX_W-1:0]             MinRow,
  output logic [IDX_W-1:0]             MinCol,
  output logic [$clog2(NUM_CORES)-1:0] MinCore,
  output logic [CNT_W-1:0]             Count,
  output logic                         Busy,
  output logic                         Done
);
  localparam int PTR_W = $clog2(NUM_CORES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]           state;
  logic [PTR_W-1:0]     ptr;
  logic [CNT_W-1:0]     exp_cnt;
  logic [NUM_CORES-1:0] grant;
  logic [PTR_W-1:0]     gidx;
  logic                 found;
  logic                 in_collect;
  logic                 fire;
  logic [CNT_W-1:0]     cnt_nx;
  logic [SAD_W-1:0]     sel_sad;
  logic [IDX_W-1:0]     sel_row;
  logic [IDX_W-1:0]     sel_col;

  // Search begins just past the last winner so every
  // continuously-valid core is served within NUM_CORES grants.
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = (int'(ptr) + k) % NUM_CORES;
      if (!found && req.ReqValid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign in_collect   = (state == S_COLLECT);
  assign fire         = in_collect & found;
  assign req.ReqReady = in_collect ? grant : '0;
  assign Busy         = in_collect;
  assign Done         = (state == S_DONE);
  assign cnt_nx       = Count + CNT_W'(1);

  assign sel_sad = req.ReqSAD[int'(gidx)*SAD_W +: SAD_W];
  assign sel_row = req.ReqRow[int'(gidx)*IDX_W +: IDX_W];
  assign sel_col = req.ReqCol[int'(gidx)*IDX_W +: IDX_W];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= S_IDLE;
      ptr     <= PTR_W'(NUM_CORES - 1);
      exp_cnt <= '0;
      MinSAD  <= '1;
      MinRow  <= '0;
      MinCol  <= '0;
      MinCore <= '0;
      Count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            exp_cnt <= ExpectedCount;
            MinSAD  <= '1;
            MinRow  <= '0;
            MinCol  <= '0;
            MinCore <= '0;
            Count   <= '0;
            state   <= (ExpectedCount == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (fire) begin
            ptr   <= gidx;
            Count <= cnt_nx;
            // Strict compare: ties keep the earlier result.
            if (sel_sad < MinSAD) begin
              MinSAD  <= sel_sad;
              MinRow  <= sel_row;
              MinCol  <= sel_col;
              MinCore <= gidx;
            end
            if (cnt_nx == exp_cnt) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sad_result_scheduler.sv
// Directed bench for sad_result_scheduler: reset, single core,
// full sweep, fairness, zero count, saturated SAD, abort.
module tb_sad_result_scheduler;
  localparam int NC = 8;
  localparam int SW = 32;
  localparam int IW = 8;
  localparam int CW = 16;

  logic          Clk;
  logic          Rst;
  logic          Start;
  logic [CW-1:0] ExpectedCount;
  logic [SW-1:0] MinSAD;
  logic [IW-1:0] MinRow;
  logic [IW-1:0] MinCol;
  logic [2:0]    MinCore;
  logic [CW-1:0] Count;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int errors = 0;

  sad_result_scheduler_if #(.NUM_CORES(NC), .SAD_W(SW), .IDX_W(IW)) bus ();

  sad_result_scheduler #(
    .NUM_CORES(NC), .SAD_W(SW), .IDX_W(IW), .CNT_W(CW)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Start(Start),
    .ExpectedCount(ExpectedCount),
    .req(bus.slave),
    .MinSAD(MinSAD),
    .MinRow(MinRow),
    .MinCol(MinCol),
    .MinCore(MinCore),
    .Count(Count),
    .Busy(Busy),
    .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_core(input int c, input logic [SW-1:0] s,
                          input logic [IW-1:0] r, input logic [IW-1:0] k);
    bus.ReqSAD[c*SW +: SW] = s;
    bus.ReqRow[c*IW +: IW] = r;
    bus.ReqCol[c*IW +: IW] = k;
  endtask

  task automatic do_reset;
    Rst = 1'b1;
    #2;
    Rst = 1'b0;
  endtask

  task automatic start(input logic [CW-1:0] ec);
    Start = 1'b1;
    ExpectedCount = ec;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    bus.ReqValid = 8'h10;
    set_core(4, 32'd3, 8'd9, 8'd9);
    start(16'd5);
    tick();
    checks++;
    if (Count !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset_count got=%0d exp=1", Count);
    end
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (MinSAD !== 32'hFFFF_FFFF || MinRow !== 8'd0 || MinCol !== 8'd0 ||
        MinCore !== 3'd0 || Count !== 16'd0) begin
      errors++;
      $display("FAIL reset_min got sad=%h row=%0d col=%0d core=%0d cnt=%0d exp ffffffff/0/0/0/0",
               MinSAD, MinRow, MinCol, MinCore, Count);
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || bus.ReqReady !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b rdy=%h exp 0/0/00",
               Busy, Done, bus.ReqReady);
    end
    Rst = 1'b0;
    bus.ReqValid = '0;
    @(negedge Clk);
  endtask

  task automatic test_single_core;
    logic [SW-1:0] sads [3] = '{32'd50, 32'd30, 32'd40};
    logic [IW-1:0] rows [3] = '{8'd1, 8'd2, 8'd4};
    logic [IW-1:0] cols [3] = '{8'd1, 8'd3, 8'd4};
    do_reset();
    start(16'd3);
    bus.ReqValid = 8'h04;
    for (int i = 0; i < 3; i++) begin
      set_core(2, sads[i], rows[i], cols[i]);
      #1;
      checks++;
      if (bus.ReqReady !== 8'h04 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL single_grant%0d got rdy=%h busy=%b exp 04/1",
                 i, bus.ReqReady, Busy);
      end
      tick();
    end
    bus.ReqValid = '0;
    #1;
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || bus.ReqReady !== 8'h00) begin
      errors++;
      $display("FAIL single_done got done=%b busy=%b rdy=%h exp 1/0/00",
               Done, Busy, bus.ReqReady);
    end
    checks++;
    if (MinSAD !== 32'd30 || MinRow !== 8'd2 || MinCol !== 8'd3 ||
        MinCore !== 3'd2 || Count !== 16'd3) begin
      errors++;
      $display("FAIL single_min got sad=%0d row=%0d col=%0d core=%0d cnt=%0d exp 30/2/3/2/3",
               MinSAD, MinRow, MinCol, MinCore, Count);
    end
    tick();
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width got done=%b exp 0", Done);
    end
  endtask

  task automatic test_all_cores;
    logic [SW-1:0] sads [8] = '{80, 70, 60, 15, 90, 20, 25, 99};
    logic [NC-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < NC; c++)
      set_core(c, sads[c], IW'(c + 10), IW'(c + 20));
    bus.ReqValid = 8'hFF;
    start(16'd8);
    for (int i = 0; i < NC; i++) begin
      exp_rdy = NC'(1) << i;
      #1;
      checks++;
      if (bus.ReqReady !== exp_rdy || Done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_grant%0d got rdy=%h done=%b exp %h/0",
                 i, bus.ReqReady, Done, exp_rdy);
      end
      tick();
    end
    bus.ReqValid = '0;
    #1;
    checks++;
    if (Done !== 1'b1 || MinSAD !== 32'd15 || MinCore !== 3'd3 ||
        MinRow !== 8'd13 || MinCol !== 8'd23 || Count !== 16'd8) begin
      errors++;
      $display("FAIL sweep_min got done=%b sad=%0d core=%0d row=%0d col=%0d cnt=%0d exp 1/15/3/13/23/8",
               Done, MinSAD, MinCore, MinRow, MinCol, Count);
    end
    tick();
  endtask

  task automatic test_fairness;
    logic [NC-1:0] exp_rdy;
    set_core(0, 32'd12, 8'd5, 8'd6);
    set_core(3, 32'd12, 8'd7, 8'd8);
    bus.ReqValid = 8'h09;
    #1;
    checks++;
    if (bus.ReqReady !== 8'h00) begin
      errors++;
      $display("FAIL idle_ready got rdy=%h exp 00", bus.ReqReady);
    end
    start(16'd6);
    for (int i = 0; i < 6; i++) begin
      exp_rdy = (i % 2 == 0) ? 8'h01 : 8'h08;
      #1;
      checks++;
      if (bus.ReqReady !== exp_rdy) begin
        errors++;
        $display("FAIL fair_grant%0d got rdy=%h exp %h",
                 i, bus.ReqReady, exp_rdy);
      end
      tick();
    end
    bus.ReqValid = '0;
    #1;
    checks++;
    if (Done !== 1'b1 || MinSAD !== 32'd12 || MinCore !== 3'd0 ||
        MinRow !== 8'd5 || MinCol !== 8'd6 || Count !== 16'd6) begin
      errors++;
      $display("FAIL fair_tie got done=%b sad=%0d core=%0d row=%0d col=%0d cnt=%0d exp 1/12/0/5/6/6",
               Done, MinSAD, MinCore, MinRow, MinCol, Count);
    end
    tick();
  endtask

  task automatic test_zero_count;
    bus.ReqValid = 8'hFF;
    Start = 1'b1;
    ExpectedCount = 16'd0;
    #1;
    checks++;
    if (bus.ReqReady !== 8'h00) begin
      errors++;
      $display("FAIL zero_ready_idle got rdy=%h exp 00", bus.ReqReady);
    end
    tick();
    Start = 1'b0;
    #1;
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || bus.ReqReady !== 8'h00 ||
        Count !== 16'd0 || MinSAD !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b rdy=%h cnt=%0d sad=%h exp 1/0/00/0/ffffffff",
               Done, Busy, bus.ReqReady, Count, MinSAD);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || bus.ReqReady !== 8'h00) begin
      errors++;
      $display("FAIL zero_after got done=%b rdy=%h exp 0/00", Done, bus.ReqReady);
    end
    bus.ReqValid = '0;
  endtask

  task automatic test_all_ones;
    set_core(6, 32'hFFFF_FFFF, 8'd9, 8'd9);
    bus.ReqValid = 8'h40;
    start(16'd1);
    #1;
    checks++;
    if (bus.ReqReady !== 8'h40) begin
      errors++;
      $display("FAIL ones_grant got rdy=%h exp 40", bus.ReqReady);
    end
    tick();
    bus.ReqValid = '0;
    checks++;
    if (Done !== 1'b1 || MinSAD !== 32'hFFFF_FFFF || MinCore !== 3'd0 ||
        MinRow !== 8'd0 || Count !== 16'd1) begin
      errors++;
      $display("FAIL ones_min got done=%b sad=%h core=%0d row=%0d cnt=%0d exp 1/ffffffff/0/0/1",
               Done, MinSAD, MinCore, MinRow, Count);
    end
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    bus.ReqValid = 8'h02;
    start(16'd8);
    for (int i = 0; i < 4; i++) begin
      set_core(1, SW'(100 - 10 * i), IW'(i), IW'(i));
      if (i == 2) begin
        Start = 1'b1;
        ExpectedCount = 16'd2;
      end
      tick();
      Start = 1'b0;
    end
    checks++;
    if (Count !== 16'd4 || Busy !== 1'b1 || MinSAD !== 32'd70) begin
      errors++;
      $display("FAIL ignore_start got cnt=%0d busy=%b sad=%0d exp 4/1/70",
               Count, Busy, MinSAD);
    end
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (Count !== 16'd0 || MinSAD !== 32'hFFFF_FFFF || Busy !== 1'b0 ||
        Done !== 1'b0 || bus.ReqReady !== 8'h00 || MinRow !== 8'd0) begin
      errors++;
      $display("FAIL abort_reset got cnt=%0d sad=%h busy=%b done=%b rdy=%h row=%0d",
               Count, MinSAD, Busy, Done, bus.ReqReady, MinRow);
    end
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet%0d got done=%b busy=%b exp 0/0", i, Done, Busy);
      end
      tick();
    end
    bus.ReqValid = 8'h20;
    start(16'd2);
    set_core(5, 32'd9, 8'd1, 8'd2);
    tick();
    set_core(5, 32'd7, 8'd3, 8'd4);
    tick();
    bus.ReqValid = '0;
    checks++;
    if (Done !== 1'b1 || MinSAD !== 32'd7 || MinCore !== 3'd5 ||
        MinRow !== 8'd3 || MinCol !== 8'd4 || Count !== 16'd2) begin
      errors++;
      $display("FAIL restart got done=%b sad=%0d core=%0d row=%0d col=%0d cnt=%0d exp 1/7/5/3/4/2",
               Done, MinSAD, MinCore, MinRow, MinCol, Count);
    end
    tick();
  endtask

  initial begin
    Rst = 1'b1;
    Start = 1'b0;
    ExpectedCount = '0;
    bus.ReqValid = '0;
    bus.ReqSAD = '0;
    bus.ReqRow = '0;
    bus.ReqCol = '0;
    @(negedge Clk);
    Rst = 1'b0;
    test_reset();
    test_single_core();
    test_all_cores();
    test_fairness();
    test_zero_count();
    test_all_ones();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
